imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_pkg.sv | 27 ++
 rtl/imm_gen_pipe_imm_extract.sv | 79 +++++++
 rtl/imm_gen_pipe.sv | 103 ++++++++++
 tb/tb_imm_gen_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and format codes for the immediate generator pipeline.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_imm_extract.sv
// Combinational RISC-V immediate decoder: raw instruction -> extended immediate and format code.
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        wide;
    fmt_e        fmt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign wide   = (XLEN == 64);

    always_comb begin
        imm32 = '0;
        fmt   = FMT_ILL;
        imm_o = '0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (wide || !instr_i[25]) fmt = FMT_SH;
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (wide) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_OP:    fmt = FMT_R;
            OPC_OP_32: if (wide) fmt = FMT_R;
            default:   fmt = FMT_ILL;
        endcase

        // shift amounts are zero-extended; every other format sign-extends from bit 31
        if (fmt == FMT_SH) begin
            if (wide) imm_o[5:0] = instr_i[25:20];
            else      imm_o[4:0] = instr_i[24:20];
        end else begin
            imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        end
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with decode at the push side and a 2-entry output skid buffer.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    logic [1:0]      count_q, count_d;
    logic [31:0]     instr0_q, instr0_d, instr1_q, instr1_d;
    logic [XLEN-1:0] imm0_q, imm0_d, imm1_q, imm1_d;
    logic [2:0]      fmt0_q, fmt0_d, fmt1_q, fmt1_d;
    logic            push, pop;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i (in_instr),
        .imm_o   (dec_imm),
        .fmt_o   (dec_fmt)
    );

    assign in_ready  = !reset && (count_q < FULL);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        count_d  = count_q;
        instr0_d = instr0_q;
        imm0_d   = imm0_q;
        fmt0_d   = fmt0_q;
        instr1_d = instr1_q;
        imm1_d   = imm1_q;
        fmt1_d   = fmt1_q;
        if (pop) begin
            instr0_d = instr1_q;
            imm0_d   = imm1_q;
            fmt0_d   = fmt1_q;
            instr1_d = '0;
            imm1_d   = '0;
            fmt1_d   = '0;
        end
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                instr0_d = in_instr;
                imm0_d   = dec_imm;
                fmt0_d   = dec_fmt;
            end else begin
                instr1_d = in_instr;
                imm1_d   = dec_imm;
                fmt1_d   = dec_fmt;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            instr0_q <= '0;
            imm0_q   <= '0;
            fmt0_q   <= '0;
            instr1_q <= '0;
            imm1_q   <= '0;
            fmt1_q   <= '0;
        end else begin
            count_q  <= count_d;
            instr0_q <= instr0_d;
            imm0_q   <= imm0_d;
            fmt0_q   <= fmt0_d;
            instr1_q <= instr1_d;
            imm1_q   <= imm1_d;
            fmt1_q   <= fmt1_d;
        end
    end

    assign out_instr   = out_valid ? instr0_q : '0;
    assign out_imm     = out_valid ? imm0_q : '0;
    assign out_fmt     = out_valid ? fmt0_q : '0;
    assign out_illegal = out_valid && (fmt0_q == FMT_ILL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] ins32, ins64, imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned accepted;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .out_valid(vld32), .out_ready(out_ready),
        .out_instr(ins32), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .out_valid(vld64), .out_ready(out_ready),
        .out_instr(ins64), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the head entry of both instances.
    task automatic head(input string tag, input logic [31:0] ins, input logic [63:0] i32,
                        input logic [2:0] f32, input logic [63:0] i64, input logic [2:0] f64);
        chk({tag, " valid32"}, 64'(vld32), 64'd1);
        chk({tag, " instr32"}, 64'(ins32), 64'(ins));
        chk({tag, " imm32"},   64'(imm32), i32);
        chk({tag, " fmt32"},   64'(fmt32), 64'(f32));
        chk({tag, " ill32"},   64'(ill32), 64'(f32 == 3'd7));
        chk({tag, " valid64"}, 64'(vld64), 64'd1);
        chk({tag, " imm64"},   64'(imm64), i64);
        chk({tag, " fmt64"},   64'(fmt64), 64'(f64));
        chk({tag, " ill64"},   64'(ill64), 64'(f64 == 3'd7));
    endtask

    task automatic idle(input string tag);
        chk({tag, " valid"}, 64'({vld32, vld64}), 64'd0);
        chk({tag, " zero"},  64'({ins32, imm32} | imm64 | 64'({fmt32, fmt64, ill32, ill64})), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        idle("reset");
        chk("reset in_ready", 64'({rdy32, rdy64}), 64'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release in_ready", 64'({rdy32, rdy64}), 64'h3);
        idle("release");

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        step();
        head("addi", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);

        in_instr = 32'hFE000EE3;
        step();
        head("beq", 32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3);
        in_instr = 32'h123450B7;
        step();
        head("lui", 32'h123450B7, 64'h12345000, 3'd4, 64'h0000000012345000, 3'd4);
        in_instr = 32'h8000006F;
        step();
        head("jal", 32'h8000006F, 64'hFFF00000, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5);
        in_instr = 32'h03F0D093;
        step();
        head("srli63", 32'h03F0D093, 64'h0, 3'd7, 64'd63, 3'd6);
        in_instr = 32'h0000007F;
        step();
        head("badop", 32'h0000007F, 64'h0, 3'd7, 64'h0, 3'd7);
        in_instr = 32'hFE112E23;
        step();
        head("sw", 32'hFE112E23, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2);
        in_instr = 32'h002081B3;
        step();
        head("add", 32'h002081B3, 64'h0, 3'd0, 64'h0, 3'd0);
        in_instr = 32'h002081BB;
        step();
        head("addw", 32'h002081BB, 64'h0, 3'd7, 64'h0, 3'd0);
        chk("stream in_ready", 64'({rdy32, rdy64}), 64'h3);

        in_valid = 1'b0;
        step();
        idle("drained");

        // Backpressure: four offered cycles, only two fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       in_instr = 32'hFFF00093;
                1:       in_instr = 32'h123450B7;
                2:       in_instr = 32'h8000006F;
                default: in_instr = 32'hFE000EE3;
            endcase
            if (rdy32) accepted++;
            step();
            head("hold", 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        end
        chk("accepted", 64'(accepted), 64'd2);
        chk("full in_ready", 64'({rdy32, rdy64}), 64'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        head("drain2", 32'h123450B7, 64'h12345000, 3'd4, 64'h0000000012345000, 3'd4);
        step();
        idle("drain_end");

        // Mid-stream asynchronous reset with a full buffer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h8000006F;
        step();
        in_instr  = 32'hFE000EE3;
        step();
        chk("prefull in_ready", 64'({rdy32, rdy64}), 64'h0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        idle("async reset");
        chk("async in_ready", 64'({rdy32, rdy64}), 64'h0);
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post in_ready", 64'({rdy32, rdy64}), 64'h3);
        idle("post reset");
        out_ready = 1'b1;
        step();
        idle("no stale");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
